// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Sole owner of the byte-serial RAM/IO port. Arbitrates between instruction
//   fetch (IF, always 4-byte reads) and the load/store buffer (LSB, 1/2/4-byte
//   reads and writes). Each request is split into per-byte RAM cycles. Read data
//   is assembled little-endian, and each request returns one data_valid pulse.
//
// Configuration macro:
//   MEMCTRL_RR_ARB_EN  defined   -> round-robin arbitration on a tie
//                      undefined -> LSB has fixed priority over IF
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready; 0 freezes state and the mem_* registers
//   clear                    mispredict flush (a store already in progress still completes)
//   if_enable/if_addr        IF request, held until if_data_valid
//   if_data_valid/if_data    1-cycle completion pulse and fetched word
//   lsb_enable/lsb_is_write/lsb_addr/lsb_data_len/lsb_write_data
//                            LSB request, held until lsb_data_valid
//   lsb_data_valid/lsb_data  1-cycle completion pulse and zero-extended load data
//   mem_din                  RAM read byte (one cycle after the address)
//   mem_dout/mem_a/mem_wr    RAM write byte, byte address, write strobe
//   io_buffer_full           stalls writes to addresses >= IO_BASE

module mem_arbiter_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_data_valid,
  output logic [31:0]       if_data,
  input  logic              lsb_enable,
  input  logic              lsb_is_write,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_data_len,
  input  logic [31:0]       lsb_write_data,
  output logic              lsb_data_valid,
  output logic [31:0]       lsb_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_nxt;

  // Latched request and transfer bookkeeping
  logic              owner_lsb, owner_lsb_nxt;
  logic [ADDR_W-1:0] base_addr, base_addr_nxt;
  logic [2:0]        len, len_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [31:0]       rbuf, rbuf_nxt;
  logic              suppress, suppress_nxt;

  // Next values of the registered outputs
  logic              if_valid_nxt, lsb_valid_nxt;
  logic [31:0]       if_data_nxt, lsb_data_nxt;
  logic [ADDR_W-1:0] mem_a_nxt;
  logic [7:0]        mem_dout_nxt;
  logic              mem_wr_nxt;

  // Request selection helpers
  logic              grant_lsb, start, req_write, accept_stall, write_stall;
  logic [ADDR_W-1:0] req_addr, byte_addr;
  logic [2:0]        req_len, lsb_len_norm;
  logic [1:0]        rx_idx;
  logic [31:0]       rx_word;
  logic [7:0]        tx_byte;

`ifdef MEMCTRL_RR_ARB_EN
  // last_lsb = 1 means the LSB is treated as the most recent winner, so IF wins the first tie.
  logic last_lsb;

  always_ff @(posedge clk) begin
    if (rst)        last_lsb <= 1'b1;
    else if (start) last_lsb <= ~last_lsb;
  end

  assign grant_lsb = lsb_enable && (!if_enable || !last_lsb);
`else
  assign grant_lsb = lsb_enable;
`endif

  // Any length other than 1 or 2 is treated as a full word.
  always_comb begin
    case (lsb_data_len)
      3'b001:  lsb_len_norm = 3'd1;
      3'b010:  lsb_len_norm = 3'd2;
      default: lsb_len_norm = 3'd4;
    endcase
  end

  assign start        = (state == IDLE) && rdy && !clear && (if_enable || lsb_enable);
  assign req_write    = grant_lsb && lsb_is_write;
  assign req_addr     = grant_lsb ? lsb_addr : if_addr;
  assign req_len      = grant_lsb ? lsb_len_norm : 3'd4;
  assign accept_stall = io_buffer_full && (req_addr >= IO_BASE);

  // The address addition wraps naturally at ADDR_W bits.
  assign byte_addr   = base_addr + ADDR_W'(cnt);
  assign write_stall = io_buffer_full && (byte_addr >= IO_BASE);
  assign tx_byte     = wdata[{cnt[1:0], 3'b000} +: 8];

  // In READ, cnt counts edges since accept. The byte on mem_din was addressed two edges earlier.
  assign rx_idx = cnt[1:0] - 2'd2;

  always_comb begin
    rx_word = rbuf;
    rx_word[{rx_idx, 3'b000} +: 8] = mem_din;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. clear takes priority over rdy. A store already in progress is committed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = req_write ? WRITE : READ;
      READ: begin
        if (clear)                          state_nxt = IDLE;
        else if (rdy && cnt == len + 3'd1)  state_nxt = DONE;
      end
      WRITE: if (rdy && cnt == len) state_nxt = DONE;
      DONE:  if (clear || rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values. Valids default low, so a frozen cycle clears them.
  always_comb begin
    owner_lsb_nxt = owner_lsb;
    base_addr_nxt = base_addr;
    len_nxt       = len;
    wdata_nxt     = wdata;
    cnt_nxt       = cnt;
    rbuf_nxt      = rbuf;
    suppress_nxt  = suppress;
    if_valid_nxt  = 1'b0;
    lsb_valid_nxt = 1'b0;
    if_data_nxt   = if_data;
    lsb_data_nxt  = lsb_data;
    mem_a_nxt     = mem_a;
    mem_dout_nxt  = mem_dout;
    mem_wr_nxt    = mem_wr;

    case (state)
      IDLE: begin
        if (start) begin
          owner_lsb_nxt = grant_lsb;
          base_addr_nxt = req_addr;
          len_nxt       = req_len;
          wdata_nxt     = lsb_write_data;
          rbuf_nxt      = '0;
          suppress_nxt  = 1'b0;
          mem_a_nxt     = req_addr;
          mem_wr_nxt    = 1'b0;
          cnt_nxt       = 3'd1;
          // Byte 0 of a store goes out on the accept edge unless the IO buffer is full.
          if (req_write) begin
            if (accept_stall) begin
              cnt_nxt = 3'd0;
            end else begin
              mem_wr_nxt   = 1'b1;
              mem_dout_nxt = lsb_write_data[7:0];
            end
          end
        end
      end

      READ: begin
        if (!clear && rdy) begin
          if (cnt < len)   mem_a_nxt = byte_addr;
          if (cnt >= 3'd2) rbuf_nxt  = rx_word;
          if (cnt == len + 3'd1) begin
            if (owner_lsb) begin
              lsb_valid_nxt = 1'b1;
              lsb_data_nxt  = rx_word;
            end else begin
              if_valid_nxt = 1'b1;
              if_data_nxt  = rx_word;
            end
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end

      WRITE: begin
        if (clear) suppress_nxt = 1'b1;
        if (rdy) begin
          if (cnt == len) begin
            mem_wr_nxt    = 1'b0;
            lsb_valid_nxt = !(suppress || clear);
          end else if (write_stall) begin
            mem_wr_nxt = 1'b0;
          end else begin
            mem_a_nxt    = byte_addr;
            mem_dout_nxt = tx_byte;
            mem_wr_nxt   = 1'b1;
            cnt_nxt      = cnt + 3'd1;
          end
        end
      end

      DONE: mem_wr_nxt = 1'b0;

      default: mem_wr_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsb      <= 1'b0;
      base_addr      <= '0;
      len            <= 3'd0;
      wdata          <= '0;
      cnt            <= 3'd0;
      rbuf           <= '0;
      suppress       <= 1'b0;
      if_data_valid  <= 1'b0;
      lsb_data_valid <= 1'b0;
      if_data        <= '0;
      lsb_data       <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr         <= 1'b0;
    end else begin
      owner_lsb      <= owner_lsb_nxt;
      base_addr      <= base_addr_nxt;
      len            <= len_nxt;
      wdata          <= wdata_nxt;
      cnt            <= cnt_nxt;
      rbuf           <= rbuf_nxt;
      suppress       <= suppress_nxt;
      if_data_valid  <= if_valid_nxt;
      lsb_data_valid <= lsb_valid_nxt;
      if_data        <= if_data_nxt;
      lsb_data       <= lsb_data_nxt;
      mem_a          <= mem_a_nxt;
      mem_dout       <= mem_dout_nxt;
      mem_wr         <= mem_wr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl
//   Directed bench for mem_arbiter_ctrl. A small RAM model returns
//   ram[mem_a[7:0]] one cycle after the address is driven. Every write strobe is
//   logged as {mem_a, mem_dout}. The valid pulses of each owner are counted.

module tb_mem_arbiter_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_data_valid;
  logic [31:0] if_data;
  logic        lsb_enable;
  logic        lsb_is_write;
  logic [31:0] lsb_addr;
  logic [2:0]  lsb_data_len;
  logic [31:0] lsb_write_data;
  logic        lsb_data_valid;
  logic [31:0] lsb_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int test_count = 0;
  int fail_count = 0;
  int if_pulses  = 0;
  int lsb_pulses = 0;

  logic [7:0]  ram [256];
  logic [39:0] wlog [$];

  mem_arbiter_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .if_enable      (if_enable),
    .if_addr        (if_addr),
    .if_data_valid  (if_data_valid),
    .if_data        (if_data),
    .lsb_enable     (lsb_enable),
    .lsb_is_write   (lsb_is_write),
    .lsb_addr       (lsb_addr),
    .lsb_data_len   (lsb_data_len),
    .lsb_write_data (lsb_write_data),
    .lsb_data_valid (lsb_data_valid),
    .lsb_data       (lsb_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read model plus the write and valid-pulse monitors
  always @(posedge clk) begin
    mem_din <= ram[mem_a[7:0]];
    if (mem_wr === 1'b1)         wlog.push_back({mem_a, mem_dout});
    if (if_data_valid === 1'b1)  if_pulses++;
    if (lsb_data_valid === 1'b1) lsb_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    assert (observed === expected)
      else begin
        fail_count++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic ie, input logic [31:0] ia, input logic le, input logic lw,
                               input logic [31:0] la, input logic [2:0] ll, input logic [31:0] lwd);
    if_enable      = ie;
    if_addr        = ia;
    lsb_enable     = le;
    lsb_is_write   = lw;
    lsb_addr       = la;
    lsb_data_len   = ll;
    lsb_write_data = lwd;
  endtask

  // Counts posedges until the chosen valid is seen on a negedge. The requester then drops its
  // enable. A timeout returns -1.
  task automatic waitValid(input logic for_lsb, input int limit, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = -1;
    for (int i = 1; i <= limit && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((for_lsb ? lsb_data_valid : if_data_valid) === 1'b1) begin
        seen   = 1'b1;
        cycles = i;
        if (for_lsb) lsb_enable = 1'b0;
        else         if_enable  = 1'b0;
      end
    end
  endtask

  function automatic logic [39:0] logEntry(input int idx);
    if (idx < wlog.size()) return wlog[idx];
    return '1;
  endfunction

  initial begin
    int cy;
    int wbase;
    int pbase;

    rst = 1'b1;
    rdy = 1'b1;
    clear = 1'b0;
    io_buffer_full = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h11;
    ram[8'h01] = 8'h22;
    ram[8'h02] = 8'h33;
    ram[8'h03] = 8'h44;
    ram[8'h04] = 8'h55;
    ram[8'hFE] = 8'h66;
    ram[8'hFF] = 8'h77;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_valid",  64'(if_data_valid),  64'h0);
    checkOutput("rst_lsb_valid", 64'(lsb_data_valid), 64'h0);
    checkOutput("rst_if_data",   64'(if_data),        64'h0);
    checkOutput("rst_lsb_data",  64'(lsb_data),       64'h0);
    checkOutput("rst_mem_a",     64'(mem_a),          64'h0);
    checkOutput("rst_mem_dout",  64'(mem_dout),       64'h0);
    checkOutput("rst_mem_wr",    64'(mem_wr),         64'h0);
    rst = 1'b0;
    @(negedge clk);

    // IF word fetch: valid six edges after the request is presented
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    waitValid(1'b0, 20, cy);
    checkOutput("lw_latency", 64'(cy), 64'd6);
    checkOutput("lw_data", 64'(if_data), 64'h44332211);
    @(negedge clk);
    checkOutput("lw_pulse_width", 64'(if_data_valid), 64'h0);

    // Unaligned halfword store
    wbase = wlog.size();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2001, 3'b010, 32'h0000BEEF);
    waitValid(1'b1, 20, cy);
    checkOutput("sh_latency", 64'(cy), 64'd3);
    @(negedge clk);
    checkOutput("sh_pulse_width", 64'(lsb_data_valid), 64'h0);
    checkOutput("sh_write_count", 64'(wlog.size() - wbase), 64'd2);
    checkOutput("sh_byte0", 64'(logEntry(wbase)),     {24'h0, 32'h2001, 8'hEF});
    checkOutput("sh_byte1", 64'(logEntry(wbase + 1)), {24'h0, 32'h2002, 8'hBE});

    // Simultaneous IF and LSB requests
    pbase = if_pulses;
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h1004, 3'b001, 32'h0);
`ifdef MEMCTRL_RR_ARB_EN
    pbase = lsb_pulses;
    waitValid(1'b0, 20, cy);
    checkOutput("tie_if_first_latency", 64'(cy), 64'd6);
    checkOutput("tie_lsb_not_yet", 64'(lsb_pulses - pbase), 64'd0);
    waitValid(1'b1, 20, cy);
    checkOutput("tie_lsb_second_latency", 64'(cy), 64'd4);
`else
    waitValid(1'b1, 20, cy);
    checkOutput("tie_lsb_first_latency", 64'(cy), 64'd3);
    checkOutput("tie_if_not_yet", 64'(if_pulses - pbase), 64'd0);
    waitValid(1'b0, 20, cy);
    checkOutput("tie_if_second_latency", 64'(cy), 64'd7);
`endif
    checkOutput("tie_lsb_data", 64'(lsb_data), 64'h55);
    checkOutput("tie_if_data",  64'(if_data),  64'h44332211);
    @(negedge clk);

    // Address wrap across the top of the address space
    applyStimulus(1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    waitValid(1'b0, 20, cy);
    checkOutput("wrap_latency", 64'(cy), 64'd6);
    checkOutput("wrap_data", 64'(if_data), 64'h22117766);
    @(negedge clk);

    // Illegal length 3 behaves as a word load
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 3'b011, 32'h0);
    waitValid(1'b1, 20, cy);
    checkOutput("len3_latency", 64'(cy), 64'd6);
    checkOutput("len3_data", 64'(lsb_data), 64'h44332211);
    @(negedge clk);

    // IO store stalled three cycles by a full buffer
    wbase = wlog.size();
    io_buffer_full = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h30000, 3'b001, 32'h0000005A);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("io_stall_wr", 64'(mem_wr), 64'h0);
    end
    io_buffer_full = 1'b0;
    waitValid(1'b1, 20, cy);
    checkOutput("io_resume_latency", 64'(cy), 64'd2);
    @(negedge clk);
    checkOutput("io_write_count", 64'(wlog.size() - wbase), 64'd1);
    checkOutput("io_write", 64'(logEntry(wbase)), {24'h0, 32'h30000, 8'h5A});

    // clear during IF read byte 2
    pbase = if_pulses;
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    if_enable = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("clear_rd_no_valid", 64'(if_pulses - pbase), 64'd0);
    checkOutput("clear_rd_data_held", 64'(if_data), 64'h22117766);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1001, 3'b001, 32'h0);
    waitValid(1'b1, 20, cy);
    checkOutput("after_clear_latency", 64'(cy), 64'd3);
    checkOutput("after_clear_data", 64'(lsb_data), 64'h22);
    @(negedge clk);

    // clear during byte 1 of a word store: all four bytes still written
    wbase = wlog.size();
    pbase = lsb_pulses;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2010, 3'b100, 32'hA1B2C3D4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    lsb_enable = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("clear_sw_count", 64'(wlog.size() - wbase), 64'd4);
    checkOutput("clear_sw_byte0", 64'(logEntry(wbase)),     {24'h0, 32'h2010, 8'hD4});
    checkOutput("clear_sw_byte2", 64'(logEntry(wbase + 2)), {24'h0, 32'h2012, 8'hB2});
    checkOutput("clear_sw_byte3", 64'(logEntry(wbase + 3)), {24'h0, 32'h2013, 8'hA1});
    checkOutput("clear_sw_no_valid", 64'(lsb_pulses - pbase), 64'd0);

    // rdy low for two cycles in the middle of a byte load
    pbase = lsb_pulses;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1002, 3'b001, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rdy = 1'b1;
    checkOutput("rdy_frozen_no_valid", 64'(lsb_pulses - pbase), 64'd0);
    waitValid(1'b1, 10, cy);
    checkOutput("rdy_resume_latency", 64'(cy), 64'd2);
    checkOutput("rdy_lb_data", 64'(lsb_data), 64'h33);
    repeat (3) @(negedge clk);
    checkOutput("rdy_one_pulse", 64'(lsb_pulses - pbase), 64'd1);

    // Reset in the middle of a store
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2020, 3'b100, 32'h01020304);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_wr_active", 64'(mem_wr), 64'h1);
    rst = 1'b1;
    lsb_enable = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wr_low", 64'(mem_wr), 64'h0);
    checkOutput("rst_mid_mem_a", 64'(mem_a), 64'h0);
    checkOutput("rst_mid_if_data", 64'(if_data), 64'h0);
    checkOutput("rst_mid_lsb_data", 64'(lsb_data), 64'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_stays_idle", 64'(mem_wr), 64'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
